// File: rtl/microwave_pkg.sv
// -----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave oven sequencer:
//   - STATE_W / state_e      : 3-bit state codes shown on the debug output
//   - BEEP_SECONDS_DEFAULT   : default end-of-cook beep duration in seconds
// Optional feature macro used by the controller: MICROWAVE_PAUSE_EN.
// -----------------------------------------------------------------------------
package microwave_pkg;

  localparam int STATE_W              = 3;
  localparam int BEEP_SECONDS_DEFAULT = 3;

  // Codes 5..7 are never produced; the controller maps them back to IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : microwave_pkg

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Single-input edge detector built on a registered previous sample.
// Parameters:
//   RISE    : 1 = detect 0->1 (~prev & sig), 0 = detect 1->0 (prev & ~sig)
//   RST_VAL : value loaded into the previous-sample register during clear;
//             chosen so a level already held through reset gives no edge.
// Ports:
//   clk     in  system clock
//   clear   in  synchronous active-high reset
//   sig_i   in  level to watch
//   edge_o  out combinational edge flag, valid in the cycle sig_i changed
// -----------------------------------------------------------------------------
module edge_detect #(
  parameter bit RISE    = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic sig_i,
  output logic edge_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) prev_q <= RST_VAL;
    else       prev_q <= sig_i;
  end

  assign edge_o = RISE ? (~prev_q & sig_i) : (prev_q & ~sig_i);

endmodule : edge_detect

// File: rtl/microwave_controller.sv
// -----------------------------------------------------------------------------
// microwave_controller
// Top-level oven sequencer. Converts button/door/keypad activity into timer
// strobes and drives the magnetron and the end-of-cook beeper.
// Optional feature: `define MICROWAVE_PAUSE_EN to make door-open / stop during
// COOK go to PAUSE (timer held) instead of clearing and returning to IDLE.
// Parameters:
//   BEEP_SECONDS  number of pgt_1Hz pulses the beeper stays on (>= 1)
// Ports:
//   clk, clear            clock, synchronous active-high reset
//   startn, stopn         active-low buttons (falling edge = press)
//   door_closed           1 = door closed
//   key_valid             keypad digit held (rising edge = new digit)
//   zero                  timer reads 00:00
//   pgt_1Hz               one-clk pulse per second
//   timer_loadn           one-cycle active-low load strobe
//   timer_enablen         active-low countdown enable (low in COOK)
//   timer_clearn          one-cycle active-low clear strobe (low in reset)
//   mag_on, beep          magnetron / beeper drive
//   state                 current state code
// -----------------------------------------------------------------------------
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int BEEP_SECONDS = BEEP_SECONDS_DEFAULT
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               startn,
  input  logic               stopn,
  input  logic               door_closed,
  input  logic               key_valid,
  input  logic               zero,
  input  logic               pgt_1Hz,
  output logic               timer_loadn,
  output logic               timer_enablen,
  output logic               timer_clearn,
  output logic               mag_on,
  output logic               beep,
  output logic [STATE_W-1:0] state
);

  localparam int              BEEP_W    = $clog2(BEEP_SECONDS + 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECONDS - 1);

  // ---------------------------------------------------------------------------
  // Input edges. Previous-sample reset values are picked so that a button held
  // down (low) or a key held through clear does not fire after release.
  // ---------------------------------------------------------------------------
  logic start_edge, stop_edge, key_edge;

  edge_detect #(.RISE(1'b0), .RST_VAL(1'b0)) u_start_edge (
    .clk    (clk),
    .clear  (clear),
    .sig_i  (startn),
    .edge_o (start_edge)
  );

  edge_detect #(.RISE(1'b0), .RST_VAL(1'b0)) u_stop_edge (
    .clk    (clk),
    .clear  (clear),
    .sig_i  (stopn),
    .edge_o (stop_edge)
  );

  edge_detect #(.RISE(1'b1), .RST_VAL(1'b1)) u_key_edge (
    .clk    (clk),
    .clear  (clear),
    .sig_i  (key_valid),
    .edge_o (key_edge)
  );

  // ---------------------------------------------------------------------------
  // Next-state and strobe decode. Priority inside each state is
  // stop > start > key.
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic              load_d, clr_d;
  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

  logic timer_loadn_q, timer_enablen_q, timer_clearn_q, mag_on_q, beep_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_d     = 1'b0;
    clr_d      = 1'b0;
    beep_cnt_d = '0;       // held at zero outside DONE, so entry starts at 0

    case (state_q)
      ST_IDLE: begin
        if (stop_edge) begin
          clr_d = 1'b1;
        end else if (key_edge) begin
          load_d  = 1'b1;
          state_d = ST_SET;
        end
      end

      ST_SET: begin
        if (stop_edge) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (start_edge && door_closed && !zero) begin
          state_d = ST_COOK;
        end else if (key_edge) begin
          load_d = 1'b1;
        end
      end

      ST_COOK: begin
        if (!door_closed || stop_edge) begin
`ifdef MICROWAVE_PAUSE_EN
          state_d = ST_PAUSE;
`else
          clr_d   = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (zero) begin
          state_d = ST_DONE;
        end
      end

`ifdef MICROWAVE_PAUSE_EN
      ST_PAUSE: begin
        if (stop_edge) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (start_edge && door_closed) begin
          state_d = ST_COOK;
        end
      end
`endif

      ST_DONE: begin
        beep_cnt_d = beep_cnt_q;
        if (stop_edge) begin
          state_d = ST_IDLE;
        end else if (pgt_1Hz) begin
          // The pulse that completes BEEP_SECONDS ends the beep on this edge.
          if (beep_cnt_q == BEEP_LAST) state_d = ST_IDLE;
          else                         beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end

      // Illegal codes (and PAUSE when the feature is compiled out) recover.
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, strobe and Moore output registers. Outputs are decoded from the
  // next state so they change on the same edge as the state code.
  // ---------------------------------------------------------------------------
  // NOTE: all control registers take a synchronous reset value; none of them
  // is storage that could be left uninitialised without corrupting control.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q         <= ST_IDLE;
      beep_cnt_q      <= '0;
      timer_loadn_q   <= 1'b1;
      timer_clearn_q  <= 1'b0;   // clear the timer along with the controller
      timer_enablen_q <= 1'b1;
      mag_on_q        <= 1'b0;
      beep_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      beep_cnt_q      <= beep_cnt_d;
      timer_loadn_q   <= ~load_d;
      timer_clearn_q  <= ~clr_d;
      timer_enablen_q <= (state_d != ST_COOK);
      mag_on_q        <= (state_d == ST_COOK);
      beep_q          <= (state_d == ST_DONE);
    end
  end

  assign timer_loadn   = timer_loadn_q;
  assign timer_enablen = timer_enablen_q;
  assign timer_clearn  = timer_clearn_q;
  assign mag_on        = mag_on_q;
  assign beep          = beep_q;
  assign state         = state_q;

endmodule : microwave_controller

// File: doc/microwave_controller.md
# microwave_controller

Top-level sequencer for the microwave oven. It turns the start and stop buttons, the door sensor and the keypad activity into control strobes for the entrada/timer/controle datapath: load, countdown enable and clear. It also drives the magnetron and the end-of-cook beeper. It sits above `control_timer` and consumes that block's `pgt_1Hz` pulse and the timer's zero flag.

## Interface
- `BEEP_SECONDS`, default 3: number of `pgt_1Hz` pulses the beeper stays on in DONE; legal range ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `startn`  in  1  start button, active-low level.
- `stopn`  in  1  stop/cancel button, active-low level.
- `door_closed`  in  1  1 = door closed.
- `key_valid`  in  1  high while any keypad digit is held; from the keypad encoder.
- `zero`  in  1  timer count is 00:00.
- `pgt_1Hz`  in  1  one-`clk` pulse per second, from `control_timer`.
- `timer_loadn`  out  1  active-low, one-cycle load strobe to the timer.
- `timer_enablen`  out  1  active-low countdown enable to the timer.
- `timer_clearn`  out  1  active-low, one-cycle clear strobe to the timer.
- `mag_on`  out  1  magnetron drive.
- `beep`  out  1  beeper drive.
- `state`  out  3  current state code, for display and debug.

## Operation
- **Edge detection.** Each edge uses a registered previous sample of its input.
  - start = `startn_prev & ~startn`.
  - stop = `stopn_prev & ~stopn`.
  - key = `~key_prev & key_valid`.
  - Reset values are `startn_prev=0`, `stopn_prev=0`, `key_prev=1`. Inputs already held through reset therefore produce no edge.
- **State codes:** IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- **IDLE**
  - key edge → pulse `timer_loadn`, go to SET.
  - stop edge → pulse `timer_clearn`, stay.
  - start edge → ignored.
- **SET**
  - key edge → pulse `timer_loadn`, stay.
  - stop edge → pulse `timer_clearn`, go to IDLE.
  - start edge with `door_closed=1` and `zero=0` → go to COOK. Otherwise start is ignored.
- **COOK**
  - Outputs: `mag_on=1`, `timer_enablen=0`.
  - Transition priority, highest first: door open (`door_closed=0`) or stop edge, then `zero=1` → DONE.
  - Action on door open or stop edge depends on the Configuration macro.
- **PAUSE**
  - Outputs: `mag_on=0`, `timer_enablen=1`; the timer value is held.
  - start edge with `door_closed=1` → COOK.
  - stop edge → pulse `timer_clearn`, go to IDLE.
  - key edges → ignored.
- **DONE**
  - Outputs: `beep=1`.
  - Beep counter, width `$clog2(BEEP_SECONDS+1)`, clears on entry and increments on each `pgt_1Hz`.
  - After `BEEP_SECONDS` pulses → IDLE.
  - stop edge → IDLE immediately.
  - start and key edges → ignored.
- **Simultaneous edges:** priority is stop > start > key.
- **Strobes:** `timer_loadn` and `timer_clearn` are never asserted in the same cycle.

## Timing
- **Reset values** (hold while `clear=1` and for the first cycle after its release):
  - `state=IDLE`, `mag_on=0`, `beep=0`, `timer_enablen=1`, `timer_loadn=1`.
  - `timer_clearn=0`, so the timer is also cleared; it returns to 1 on the cycle after `clear` is released.
- **Edge latency:** an input changing before rising edge k is detected at edge k. The state register updates at edge k, and the registered strobe is low from edge k to edge k+1, exactly one cycle.
- **Output decode:** `mag_on`, `beep`, `timer_enablen` and `state` are registered Moore outputs, valid from edge k.
- **Zero:** `zero` asserted before edge k while in COOK gives `mag_on=0` and `beep=1` from edge k.
- **Reset mid-operation:** `clear` in any state forces IDLE at the next edge; the magnetron is off one cycle later at most.

## Configuration
- Macro: `MICROWAVE_PAUSE_EN`.
- **Defined:** door open or stop edge in COOK → PAUSE; the timer value is kept.
- **Undefined:** door open or stop edge in COOK → pulse `timer_clearn`, go to IDLE. PAUSE is unreachable and treated as illegal (→ IDLE).

## Structure
- Package `microwave_pkg` holds:
  - the state code constants and their 3-bit width;
  - the default beep duration constant.
- Sub-module `edge_detect` has parameters for polarity (rise/fall) and for the reset value of the previous-sample register. It is instantiated three times.
- The FSM, strobe registers and beep counter all live in `microwave_controller`.

## Test plan
1. Hold `clear`=1 for 2 cycles → `state=0`, `timer_clearn=0`, `mag_on=0`. Release → `timer_clearn=1` one cycle later.
2. Raise `key_valid` twice from IDLE with door closed → each rise gives one cycle of `timer_loadn=0`, `state=1`. Then `zero=0` and a start edge → `state=2`, `mag_on=1`, `timer_enablen=0` at the same edge.
3. In COOK, raise `zero` → `state=4`, `beep=1`. With `BEEP_SECONDS=3`, `beep` stays high until the third `pgt_1Hz`, then `state=0`.
4. `MICROWAVE_PAUSE_EN` defined: open the door in COOK → `state=3`, `mag_on=0`. Close the door and give a start edge → `state=2`. Undefined: the same stimulus → `state=0` plus one `timer_clearn` pulse.
5. In SET, give a start edge with `door_closed=0`, then separately with `zero=1` → `state` stays 1 and `mag_on` stays 0 in both cases.
6. Assert `startn` and `stopn` edges in the same cycle in SET → stop wins: `state=0` and one `timer_clearn` pulse. Then hold `startn` low through `clear` → no COOK after release.
